// File: rtl/bit_reduce_pkg.sv
// -----------------------------------------------------------------------------
// bit_reduce_pkg
//   Shared definitions for the bit_reduce_acc frame reducer.
//   - MODE_* : operator encodings carried on the 2-bit mode input.
//   - state_e: FSM state encoding used by the top level.
// -----------------------------------------------------------------------------
package bit_reduce_pkg;

   localparam logic [1:0] MODE_AND  = 2'b00;
   localparam logic [1:0] MODE_OR   = 2'b01;
   localparam logic [1:0] MODE_XOR  = 2'b10;
   localparam logic [1:0] MODE_XNOR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/bit_reduce_core.sv
// -----------------------------------------------------------------------------
// bit_reduce_core
//   Combinational per-beat reduce and accumulate step.
//   Ports:
//     data    in  WIDTH  beat operand
//     mode    in  2      operator (MODE_AND/OR/XOR/XNOR)
//     acc_in  in  1      running accumulator
//     first   in  1      1 = first beat of a frame, load instead of combine
//     acc_out out 1      next accumulator value
// -----------------------------------------------------------------------------
module bit_reduce_core
   import bit_reduce_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   input  logic [1:0]       mode,
   input  logic             acc_in,
   input  logic             first,
   output logic             acc_out
);

   logic beat_r;

   always_comb begin
      beat_r  = 1'b0;
      acc_out = 1'b0;

      case (mode)
         MODE_AND: beat_r = &data;
         MODE_OR:  beat_r = |data;
         default:  beat_r = ^data;  // XOR and XNOR share the parity reduce
      endcase

      if (first) begin
         acc_out = beat_r;
      end else begin
         case (mode)
            MODE_AND: acc_out = acc_in & beat_r;
            MODE_OR:  acc_out = acc_in | beat_r;
            // XNOR is accumulated as XOR; the inversion happens once at the output
            default:  acc_out = acc_in ^ beat_r;
         endcase
      end
   end

endmodule

// File: rtl/bit_reduce_acc.sv
// -----------------------------------------------------------------------------
// bit_reduce_acc
//   Reduces a frame of WIDTH-bit beats to one bit with a selectable operator,
//   accumulating across beats. valid/ready on input and output.
//   Optional feature macro: BIT_REDUCE_SAT_FLAG_EN (adds out_sat).
//   Ports:
//     clk        in   1      clock, posedge
//     rst        in   1      synchronous active-high reset
//     mode       in   2      operator, sampled on the first beat of a frame
//     in_valid   in   1      input beat valid
//     in_ready   out  1      block can accept a beat
//     in_data    in   WIDTH  beat operand
//     in_last    in   1      final beat of frame
//     out_valid  out  1      result valid
//     out_ready  in   1      consumer accepts result
//     out_y      out  1      reduced frame result
//     out_sat    out  1      (BIT_REDUCE_SAT_FLAG_EN only) beat count saturated
//     out_beats  out  CNT_W  beats in frame, saturating
// -----------------------------------------------------------------------------
module bit_reduce_acc
   import bit_reduce_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_y,
`ifdef BIT_REDUCE_SAT_FLAG_EN
   output logic             out_sat,
`endif
   output logic [CNT_W-1:0] out_beats
);

   localparam logic [CNT_W-1:0] BeatsMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] BeatsOne = CNT_W'(1);

   state_e           state_q, state_d;
   logic             acc_q, acc_d;
   logic [CNT_W-1:0] beats_q, beats_d;
   logic [1:0]       mode_q, mode_d;

   logic             accept;
   logic             first;
   logic [1:0]       core_mode;
   logic             core_acc;

   // Held low throughout reset so nothing is accepted while the frame is discarded
   assign in_ready  = ~rst & (state_q != ST_HOLD);
   assign accept    = in_valid & in_ready;
   assign first     = (state_q == ST_IDLE);
   // Live mode only on the first beat; the latched copy governs the rest of the frame
   assign core_mode = first ? mode : mode_q;

   bit_reduce_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .data    (in_data),
      .mode    (core_mode),
      .acc_in  (acc_q),
      .first   (first),
      .acc_out (core_acc)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      beats_d = beats_q;
      mode_d  = mode_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               mode_d  = mode;
               acc_d   = core_acc;
               beats_d = BeatsOne;
               state_d = in_last ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (accept) begin
               acc_d   = core_acc;
               beats_d = (beats_q == BeatsMax) ? BeatsMax : beats_q + BeatsOne;
               if (in_last) begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= 1'b0;
         beats_q <= '0;
         mode_q  <= MODE_AND;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         beats_q <= beats_d;
         mode_q  <= mode_d;
      end
   end

   assign out_valid = (state_q == ST_HOLD);
   assign out_y     = out_valid & ((mode_q == MODE_XNOR) ? ~acc_q : acc_q);
   assign out_beats = beats_q;

`ifdef BIT_REDUCE_SAT_FLAG_EN
   logic sat_q, sat_d;

   // Set when a beat arrives while the counter already sits at its maximum
   always_comb begin
      sat_d = sat_q;
      if (state_q == ST_HOLD && out_ready) begin
         sat_d = 1'b0;
      end else if (accept && state_q == ST_ACCUM && beats_q == BeatsMax) begin
         sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sat_q <= 1'b0;
      end else begin
         sat_q <= sat_d;
      end
   end

   assign out_sat = sat_q & out_valid;
`endif

endmodule
